// File: rtl/cpu_pkg.sv
// Shared constants and types for the rename stage and its free list.
package cpu_pkg;

  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned NUM_PHYS  = 64;
  localparam int unsigned PREG_W    = $clog2(NUM_PHYS);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [4:0]        areg_t;

endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical registers, preloaded with 32..NumPhys-1 at reset.
module rename_free_list #(
  parameter int unsigned NumPhys = 64,
  parameter int unsigned PregW   = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [PregW-1:0] push_data_i,
  input  logic             pop_i,
  output logic [PregW-1:0] head_o,
  output logic [PregW:0]   count_o,
  output logic             empty_o
);
  import cpu_pkg::*;

  localparam int unsigned Depth = NumPhys - ARCH_REGS;
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = PregW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

  logic [PregW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  // Depth need not be a power of two, so wrap explicitly rather than by overflow.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  // Pointer and occupancy next-state; a push into a full list is dropped.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_ok) begin
      head_d = next_ptr(head_q);
    end
    if (push_ok) begin
      tail_d = next_ptr(tail_q);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= DepthCnt;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage: reset preloads every slot, after which only retires write at tail.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= PregW'(ARCH_REGS + i);
      end
    end else if (push_ok) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

  // A retire into a full list means a register was freed twice upstream.
  overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full));

endmodule

// File: rtl/rename_stage.sv
// Register rename: RAT lookup/update plus free-list allocation, one instruction per cycle.
module rename_stage #(
  parameter int unsigned NUM_PHYS = cpu_pkg::NUM_PHYS,
  parameter int unsigned PREG_W   = $clog2(NUM_PHYS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  cpu_pkg::areg_t       in_rs1,
  input  cpu_pkg::areg_t       in_rs2,
  input  cpu_pkg::areg_t       in_rd,
  input  logic                 in_reg_write,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PREG_W-1:0]    out_prs1,
  output logic [PREG_W-1:0]    out_prs2,
  output logic [PREG_W-1:0]    out_prd,
  output logic [PREG_W-1:0]    out_old_prd,
  output logic                 out_alloc,
  input  logic                 retire_valid,
  input  logic [PREG_W-1:0]    retire_preg,
  output logic [PREG_W:0]      free_count
);
  import cpu_pkg::*;

  logic [PREG_W-1:0] rat_q [ARCH_REGS];

  logic              out_valid_q, out_valid_d;
  logic [PREG_W-1:0] out_prs1_q, out_prs1_d;
  logic [PREG_W-1:0] out_prs2_q, out_prs2_d;
  logic [PREG_W-1:0] out_prd_q, out_prd_d;
  logic [PREG_W-1:0] out_old_prd_q, out_old_prd_d;
  logic              out_alloc_q, out_alloc_d;

  logic              need_alloc;
  logic              accept;
  logic              fl_push;
  logic              fl_empty;
  logic [PREG_W-1:0] fl_head;
  logic [PREG_W:0]   fl_count;

  // x0 never gets a fresh register, so it stays pinned to physical 0.
  assign need_alloc = in_reg_write && (in_rd != '0);
  assign in_ready   = (!out_valid_q || out_ready) && (!need_alloc || !fl_empty);
  assign accept     = in_valid && in_ready;
  assign fl_push    = retire_valid && (retire_preg != '0);

  rename_free_list #(
    .NumPhys (NUM_PHYS),
    .PregW   (PREG_W)
  ) u_free_list (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (fl_push),
    .push_data_i (retire_preg),
    .pop_i       (accept && need_alloc),
    .head_o      (fl_head),
    .count_o     (fl_count),
    .empty_o     (fl_empty)
  );

  // Output register next-state; sources read the RAT before this instruction's own write.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_prs1_d    = out_prs1_q;
    out_prs2_d    = out_prs2_q;
    out_prd_d     = out_prd_q;
    out_old_prd_d = out_old_prd_q;
    out_alloc_d   = out_alloc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_prs1_d  = rat_q[in_rs1];
      out_prs2_d  = rat_q[in_rs2];
      if (need_alloc) begin
        out_prd_d     = fl_head;
        out_old_prd_d = rat_q[in_rd];
        out_alloc_d   = 1'b1;
      end else begin
        out_prd_d     = '0;
        out_old_prd_d = '0;
        out_alloc_d   = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_prs1_q    <= '0;
      out_prs2_q    <= '0;
      out_prd_q     <= '0;
      out_old_prd_q <= '0;
      out_alloc_q   <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_prs1_q    <= out_prs1_d;
      out_prs2_q    <= out_prs2_d;
      out_prd_q     <= out_prd_d;
      out_old_prd_q <= out_old_prd_d;
      out_alloc_q   <= out_alloc_d;
    end
  end

  // RAT: identity map at reset, destination remapped to the popped free register on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        rat_q[i] <= PREG_W'(i);
      end
    end else if (accept && need_alloc) begin
      rat_q[in_rd] <= fl_head;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_prs1    = out_prs1_q;
  assign out_prs2    = out_prs2_q;
  assign out_prd     = out_prd_q;
  assign out_old_prd = out_old_prd_q;
  assign out_alloc   = out_alloc_q;
  assign free_count  = fl_count;

endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage: vector table, directed corner sequences, random vs model.
module tb_rename_stage;

  localparam int NP    = 64;
  localparam int PW    = 6;
  localparam int DEPTH = NP - 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_reg_write;
  logic [4:0]    in_rs1, in_rs2, in_rd;
  logic          out_valid, out_ready, out_alloc;
  logic [PW-1:0] out_prs1, out_prs2, out_prd, out_old_prd;
  logic          retire_valid;
  logic [PW-1:0] retire_preg;
  logic [PW:0]   free_count;

  always #5 clk = ~clk;

  rename_stage #(
    .NUM_PHYS (NP),
    .PREG_W   (PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_prs1     (out_prs1),
    .out_prs2     (out_prs2),
    .out_prd      (out_prd),
    .out_old_prd  (out_old_prd),
    .out_alloc    (out_alloc),
    .retire_valid (retire_valid),
    .retire_preg  (retire_preg),
    .free_count   (free_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: RAT as an int array, free list as a FIFO queue.
  int m_rat [32];
  int m_fl [$];
  int m_pool [$];  // registers safe to retire (displaced old mappings)
  bit m_ov, m_alloc;
  int m_prs1, m_prs2, m_prd, m_old;
  bit last_rdy;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_rat[i] = i;
    m_fl.delete();
    for (int p = 32; p < NP; p++) m_fl.push_back(p);
    m_pool.delete();
    m_ov = 0; m_alloc = 0;
    m_prs1 = 0; m_prs2 = 0; m_prd = 0; m_old = 0;
  endfunction

  task automatic set_in(input bit iv, input int rs1, input int rs2, input int rd, input bit rw,
                        input bit ordy, input bit rv, input int rp);
    in_valid = iv; in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_rd = 5'(rd);
    in_reg_write = rw; out_ready = ordy; retire_valid = rv; retire_preg = PW'(rp);
  endtask

  // Called at posedge+1 with inputs set; ends at the next posedge+1 with outputs checked.
  task automatic step();
    bit need, rdy;
    int old_size;
    #1;
    need = in_reg_write && (in_rd != 0);
    rdy  = (!m_ov || out_ready) && (!need || m_fl.size() != 0);
    last_rdy = in_ready;
    check("in_ready", in_ready, rdy);
    @(posedge clk);
    old_size = m_fl.size();
    if (in_valid && rdy) begin
      m_prs1 = m_rat[in_rs1];
      m_prs2 = m_rat[in_rs2];
      if (need) begin
        m_prd = m_fl.pop_front();
        m_old = m_rat[in_rd];
        m_rat[in_rd] = m_prd;
        m_alloc = 1;
        m_pool.push_back(m_old);
      end else begin
        m_prd = 0; m_old = 0; m_alloc = 0;
      end
      m_ov = 1;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (retire_valid && retire_preg != 0 && old_size < DEPTH) m_fl.push_back(int'(retire_preg));
    #1;
    check("out_valid", out_valid, m_ov);
    check("free_count", free_count, m_fl.size());
    if (m_ov) begin
      check("out_prs1", out_prs1, m_prs1);
      check("out_prs2", out_prs2, m_prs2);
      check("out_prd", out_prd, m_prd);
      check("out_old_prd", out_old_prd, m_old);
      check("out_alloc", out_alloc, m_alloc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_prd", out_prd, 0);
    check("rst_out_prs1", out_prs1, 0);
    check("rst_out_old_prd", out_old_prd, 0);
    check("rst_out_alloc", out_alloc, 0);
    check("rst_free_count", free_count, DEPTH);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit iv; int rs1; int rs2; int rd; bit rw; bit ordy; bit rv; int rp;
    bit e_rdy; bit e_valid; int e_prs1; int e_prs2; int e_prd; int e_old; bit e_alloc; int e_fc;
  } vec_t;

  vec_t tbl [7];

  initial begin
    // iv rs1 rs2 rd rw ordy rv rp | rdy valid prs1 prs2 prd old alloc fc
    tbl[0] = '{1, 1, 2, 3, 1, 1, 0, 0,  1, 1,  1,  2, 32,  3, 1, 31};
    tbl[1] = '{1, 3, 3, 3, 1, 1, 0, 0,  1, 1, 32, 32, 33, 32, 1, 30};
    tbl[2] = '{1, 4, 5, 0, 1, 1, 0, 0,  1, 1,  4,  5,  0,  0, 0, 30};
    tbl[3] = '{1, 3, 6, 7, 0, 1, 0, 0,  1, 1, 33,  6,  0,  0, 0, 30};
    tbl[4] = '{1, 7, 0, 7, 1, 1, 0, 0,  1, 1,  7,  0, 34,  7, 1, 29};
    tbl[5] = '{1, 0, 3, 9, 1, 1, 1, 3,  1, 1,  0, 33, 35,  9, 1, 29};
    tbl[6] = '{0, 0, 0, 0, 0, 1, 1, 0,  1, 0,  0,  0,  0,  0, 0, 29};

    // Vector table from reset.
    do_reset();
    for (int v = 0; v < 7; v++) begin
      set_in(tbl[v].iv, tbl[v].rs1, tbl[v].rs2, tbl[v].rd, tbl[v].rw, tbl[v].ordy,
             tbl[v].rv, tbl[v].rp);
      step();
      check($sformatf("vec%0d_rdy", v), last_rdy, tbl[v].e_rdy);
      check($sformatf("vec%0d_valid", v), out_valid, tbl[v].e_valid);
      check($sformatf("vec%0d_fc", v), free_count, tbl[v].e_fc);
      if (tbl[v].e_valid) begin
        check($sformatf("vec%0d_prs1", v), out_prs1, tbl[v].e_prs1);
        check($sformatf("vec%0d_prs2", v), out_prs2, tbl[v].e_prs2);
        check($sformatf("vec%0d_prd", v), out_prd, tbl[v].e_prd);
        check($sformatf("vec%0d_old", v), out_old_prd, tbl[v].e_old);
        check($sformatf("vec%0d_alloc", v), out_alloc, tbl[v].e_alloc);
      end
    end

    // Drain the free list, stall on empty, retire in the stall cycle.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      set_in(1, $urandom_range(31), $urandom_range(31), 1 + (i % 31), 1, 1, 0, 0);
      step();
    end
    check("drain_fc", free_count, 0);
    check("drain_last_prd", out_prd, 63);
    set_in(1, 1, 2, 4, 1, 1, 1, 5);
    step();
    check("empty_stall_rdy", last_rdy, 0);
    set_in(1, 1, 2, 4, 1, 1, 0, 0);
    step();
    check("after_stall_rdy", last_rdy, 1);
    check("after_stall_prd", out_prd, 5);

    // Backpressure: out_ready low for 3 cycles holds everything.
    for (int r = 7; r <= 9; r++) begin
      set_in(0, 0, 0, 0, 0, 1, 1, r);
      step();
    end
    set_in(1, 2, 3, 10, 1, 1, 0, 0);
    step();
    check("bp_first_prd", out_prd, 7);
    for (int k = 0; k < 3; k++) begin
      set_in(1, 4, 5, 11, 1, 0, 0, 0);
      step();
      check("bp_rdy", last_rdy, 0);
      check("bp_valid", out_valid, 1);
      check("bp_prd", out_prd, 7);
      check("bp_fc", free_count, 2);
    end
    set_in(1, 4, 5, 11, 1, 1, 0, 0);
    step();
    check("bp_release_prd", out_prd, 8);

    // Simultaneous retire and allocate at count 10; FIFO order is preserved.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      set_in(1, 0, 0, 1 + (i % 31), 1, 1, 0, 0);
      step();
    end
    check("c10_fc", free_count, 10);
    set_in(1, 0, 0, 5, 1, 1, 1, 40);
    step();
    check("c10_same_cycle_fc", free_count, 10);
    check("c10_same_cycle_prd", out_prd, 54);
    for (int j = 0; j < 9; j++) begin
      set_in(1, 0, 0, 6, 1, 1, 0, 0);
      step();
      check("c10_order_prd", out_prd, 55 + j);
    end
    set_in(1, 0, 0, 6, 1, 1, 0, 0);
    step();
    check("c10_retired_prd", out_prd, 40);

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 1 + i, 1, 1, 0, 0);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_fc", free_count, DEPTH);
    check("async_rst_prd", out_prd, 0);
    do_reset();
    for (int i = 0; i < 32; i++) begin
      set_in(1, i, 31 - i, 0, 0, 1, 0, 0);
      step();
      check("ident_prs1", out_prs1, i);
      check("ident_prs2", out_prs2, 31 - i);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      bit rv;
      int rp;
      rv = 0; rp = 0;
      if (m_pool.size() != 0 && $urandom_range(2) == 0) begin
        rv = 1; rp = m_pool.pop_front();
      end else if ($urandom_range(9) == 0) begin
        rv = 1; rp = 0;
      end
      set_in($urandom_range(3) != 0, $urandom_range(31), $urandom_range(31), $urandom_range(31),
             $urandom_range(3) != 0, $urandom_range(3) != 0, rv, rp);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Sits directly downstream of decode, upstream of the issue queue.
- Maps decoded architectural register fields (rs1, rs2, rd) to physical registers using a register alias table (RAT) and a free list of physical registers.
- Returns physical registers to the free list when instructions retire.
- Valid/ready handshake on both sides; one instruction renamed per cycle.

Parameters:
- NUM_PHYS, 64, number of physical registers; must be greater than 32 and a power of two.
- PREG_W, 6, physical register index width, equal to clog2(NUM_PHYS).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage accepts the instruction this cycle.
- in_rs1  input  5  architectural source 1.
- in_rs2  input  5  architectural source 2.
- in_rd  input  5  architectural destination.
- in_reg_write  input  1  instruction writes rd.
- out_valid  output  1  renamed instruction valid.
- out_ready  input  1  downstream accepts.
- out_prs1  output  PREG_W  physical source 1.
- out_prs2  output  PREG_W  physical source 2.
- out_prd  output  PREG_W  newly allocated destination; 0 if none.
- out_old_prd  output  PREG_W  previous mapping of rd; carried to the ROB for freeing at retire.
- out_alloc  output  1  out_prd is a fresh allocation.
- retire_valid  input  1  one physical register is freed this cycle.
- retire_preg  input  PREG_W  register to free.
- free_count  output  PREG_W+1  number of free-list entries.

Behaviour:
- Reset (async, rst_n low):
  - RAT[i] = i for i in 0..31.
  - Free list holds 32..NUM_PHYS-1 in ascending order; head = 0, tail = 0, count = NUM_PHYS-32.
  - out_valid = 0; all out_* data = 0; free_count = NUM_PHYS-32.
- Reset asserted mid-operation discards the in-flight output register and any pending free. No partial state survives.
- Allocation is needed when in_reg_write = 1 and in_rd != 0.
- in_ready = (!out_valid || out_ready) && (!need_alloc || count != 0). The ready path is combinational.
- Accept occurs when in_valid && in_ready. On the next clock edge:
  - out_prs1 = RAT[in_rs1] and out_prs2 = RAT[in_rs2], read before this instruction's own update. An instruction with rs1 == rd therefore sees the old mapping.
  - If need_alloc: out_prd = free list head, out_old_prd = RAT[in_rd], RAT[in_rd] <= head, head++, count--, out_alloc = 1.
  - Otherwise: out_prd = 0, out_old_prd = 0, out_alloc = 0; RAT and free list are unchanged.
  - out_valid = 1.
- Latency is one cycle from accept to out_valid.
- out_valid && !out_ready: all out_* hold stable and no new accept occurs.
- No accept && out_ready: out_valid clears at the next edge.
- Retire: when retire_valid = 1 and retire_preg != 0, the free list writes retire_preg at tail, tail++, count++. retire_preg == 0 is ignored.
- Same-cycle allocate and retire: count is unchanged net.
- A register freed in cycle N is allocatable no earlier than cycle N+1; there is no bypass.
- With the free list empty and need_alloc set, in_ready = 0 for that cycle. A retire in that same cycle does not release the stall until the next cycle.
- Head and tail wrap modulo (NUM_PHYS-32) with no gap at the wrap point.
- A retire when count == NUM_PHYS-32 is an illegal overflow. The simulation assertion fires and the free list state is unchanged.
- Physical register 0 is never allocated and never freed. Architectural x0 always maps to 0.

Decomposition:
- Shared package cpu_pkg:
  - constants ARCH_REGS = 32, NUM_PHYS, PREG_W;
  - typedef preg_t (logic [PREG_W-1:0]);
  - typedef areg_t (logic [4:0]).
- Sub-module rename_free_list: circular FIFO with push, pop, count, and reset preload of 32..NUM_PHYS-1.
- The RAT stays inline as a flop array inside rename_stage, because it needs a same-cycle read-before-write.

Test Plan:
- Reset, then accept {rs1=1, rs2=2, rd=3, reg_write=1} -> next cycle out_prs1=1, out_prs2=2, out_prd=32, out_old_prd=3, out_alloc=1, free_count=31.
- Follow-up {rs1=3, rs2=3, rd=3} -> out_prs1=32, out_prs2=32, out_prd=33, out_old_prd=32.
- Instructions with rd=0 and with reg_write=0 (store-like) -> out_prd=0, out_alloc=0, free_count unchanged.
- Back-to-back allocate 32 instructions with out_ready=1 -> free_count=0; the 33rd allocating instruction sees in_ready=0.
  - Retire preg 5 in the stall cycle -> in_ready rises the next cycle and out_prd=5.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0, no free-list movement.
- Simultaneous retire(40) and allocate at count=10 -> count stays 10; 40 is handed out after the 10 older entries in FIFO order.
- Assert rst_n low mid-stream after 5 allocations -> RAT is identity, free_count=32, out_valid=0 immediately (asynchronous).
